// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS for the AD9708 data bus.
// A 32-bit accumulator advances by the registered tuning word. Its top 8 bits
// plus a static phase offset pick one of sine (quarter-wave LUT), triangle,
// sawtooth or square. Output is 8-bit offset binary. wrap_sync marks the
// first sample after each accumulator wrap.
// Pipeline: tw -> acc -> S1 (phase) -> S2 (raw wave) -> S3 (dac_data).
// The acc value written at edge k shows on dac_data at edge k+3.
// rst_n is synchronous and active-low, and it overrides every other input.
module dds_wave_gen #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 6,
  parameter int DAC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] fre_k,
  input  logic               en,
  input  logic [1:0]         wave_sel,
  input  logic [7:0]         phase_off,
  output logic [DAC_W-1:0]   dac_data,
  output logic               wrap_sync
);

  localparam logic [DAC_W-1:0] MIDSCALE = DAC_W'(1) << (DAC_W - 1);

  // Tuning word and accumulator
  logic [PHASE_W-1:0] tw_q, tw_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W:0]   acc_sum;
  logic               wrap_q, wrap_d;

  // S1: output phase after offset
  logic [7:0]         p_q, p_d;
  logic [1:0]         sel1_q, sel1_d;
  logic               w1_q, w1_d;

  // S2: raw waveform value
  logic [DAC_W-1:0]   raw_q, raw_d;
  logic               w2_q, w2_d;

  // S3: DAC output register
  logic [DAC_W-1:0]   dac_q, dac_d;
  logic               wrap_sync_q, wrap_sync_d;

  // Sine lookup helpers
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  lut_idx;
  logic [6:0]         lut_val;
  logic [DAC_W-1:0]   sine_val;
  logic [DAC_W-1:0]   tri_val;

  // Accumulator next state: carry-out of the add is the wrap flag; hold when disabled
  always_comb begin
    tw_d    = fre_k;
    acc_sum = {1'b0, acc_q} + {1'b0, tw_q};
    acc_d   = acc_q;
    wrap_d  = 1'b0;
    if (en) begin
      acc_d  = acc_sum[PHASE_W-1:0];
      wrap_d = acc_sum[PHASE_W];
    end
  end

  // S1 next state: apply the phase offset to the top byte of the accumulator
  always_comb begin
    p_d    = acc_q[PHASE_W-1 -: 8] + phase_off;
    sel1_d = wave_sel;
    w1_d   = wrap_q;
  end

  // Quarter-wave table: L[i] = round(127*sin(pi*i/128))
  always_comb begin
    lut_val = 7'd0;
    case (lut_idx)
      6'd0:  lut_val = 7'd0;    6'd1:  lut_val = 7'd3;
      6'd2:  lut_val = 7'd6;    6'd3:  lut_val = 7'd9;
      6'd4:  lut_val = 7'd12;   6'd5:  lut_val = 7'd16;
      6'd6:  lut_val = 7'd19;   6'd7:  lut_val = 7'd22;
      6'd8:  lut_val = 7'd25;   6'd9:  lut_val = 7'd28;
      6'd10: lut_val = 7'd31;   6'd11: lut_val = 7'd34;
      6'd12: lut_val = 7'd37;   6'd13: lut_val = 7'd40;
      6'd14: lut_val = 7'd43;   6'd15: lut_val = 7'd46;
      6'd16: lut_val = 7'd49;   6'd17: lut_val = 7'd51;
      6'd18: lut_val = 7'd54;   6'd19: lut_val = 7'd57;
      6'd20: lut_val = 7'd60;   6'd21: lut_val = 7'd63;
      6'd22: lut_val = 7'd65;   6'd23: lut_val = 7'd68;
      6'd24: lut_val = 7'd71;   6'd25: lut_val = 7'd73;
      6'd26: lut_val = 7'd76;   6'd27: lut_val = 7'd78;
      6'd28: lut_val = 7'd81;   6'd29: lut_val = 7'd83;
      6'd30: lut_val = 7'd85;   6'd31: lut_val = 7'd88;
      6'd32: lut_val = 7'd90;   6'd33: lut_val = 7'd92;
      6'd34: lut_val = 7'd94;   6'd35: lut_val = 7'd96;
      6'd36: lut_val = 7'd98;   6'd37: lut_val = 7'd100;
      6'd38: lut_val = 7'd102;  6'd39: lut_val = 7'd104;
      6'd40: lut_val = 7'd106;  6'd41: lut_val = 7'd107;
      6'd42: lut_val = 7'd109;  6'd43: lut_val = 7'd111;
      6'd44: lut_val = 7'd112;  6'd45: lut_val = 7'd113;
      6'd46: lut_val = 7'd115;  6'd47: lut_val = 7'd116;
      6'd48: lut_val = 7'd117;  6'd49: lut_val = 7'd118;
      6'd50: lut_val = 7'd120;  6'd51: lut_val = 7'd121;
      6'd52: lut_val = 7'd122;  6'd53: lut_val = 7'd122;
      6'd54: lut_val = 7'd123;  6'd55: lut_val = 7'd124;
      6'd56: lut_val = 7'd125;  6'd57: lut_val = 7'd125;
      6'd58: lut_val = 7'd126;  6'd59: lut_val = 7'd126;
      6'd60: lut_val = 7'd126;  6'd61: lut_val = 7'd127;
      6'd62: lut_val = 7'd127;  6'd63: lut_val = 7'd127;
      default: lut_val = 7'd0;
    endcase
  end

  // S2 next state: waveform shaping from the registered phase.
  // Odd quadrants read the table mirrored (63-idx == ~idx); the upper half subtracts from midscale.
  always_comb begin
    quad     = p_q[7:6];
    lut_idx  = quad[0] ? ~p_q[LUT_AW-1:0] : p_q[LUT_AW-1:0];
    sine_val = quad[1] ? (MIDSCALE - {1'b0, lut_val}) : (MIDSCALE + {1'b0, lut_val});
    tri_val  = p_q[7] ? ~{p_q[6:0], 1'b0} : {p_q[6:0], 1'b0};
    raw_d    = sine_val;
    case (sel1_q)
      2'd0:    raw_d = sine_val;
      2'd1:    raw_d = tri_val;
      2'd2:    raw_d = p_q;
      2'd3:    raw_d = p_q[7] ? 8'h00 : 8'hFF;
      default: raw_d = sine_val;
    endcase
    w2_d = w1_q;
  end

  // S3 next state: register the sample and its wrap marker for the DAC pins
  always_comb begin
    dac_d       = raw_q;
    wrap_sync_d = w2_q;
  end

  // All state registers; the raw stage clears to midscale so reset never shows a glitch sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tw_q        <= '0;
      acc_q       <= '0;
      wrap_q      <= 1'b0;
      p_q         <= '0;
      sel1_q      <= '0;
      w1_q        <= 1'b0;
      raw_q       <= MIDSCALE;
      w2_q        <= 1'b0;
      dac_q       <= MIDSCALE;
      wrap_sync_q <= 1'b0;
    end else begin
      tw_q        <= tw_d;
      acc_q       <= acc_d;
      wrap_q      <= wrap_d;
      p_q         <= p_d;
      sel1_q      <= sel1_d;
      w1_q        <= w1_d;
      raw_q       <= raw_d;
      w2_q        <= w2_d;
      dac_q       <= dac_d;
      wrap_sync_q <= wrap_sync_d;
    end
  end

  assign dac_data  = dac_q;
  assign wrap_sync = wrap_sync_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen.
// At every clock edge a reference model pushes the expected sample for that
// phase into exp_q, tagged with the edge it is due on. A negedge monitor pops
// each entry and compares it with dac_data and wrap_sync.
module tb_dds_wave_gen;

  logic        clk;
  logic        rst_n;
  logic [31:0] fre_k;
  logic        en;
  logic [1:0]  wave_sel;
  logic [7:0]  phase_off;
  logic [7:0]  dac_data;
  logic        wrap_sync;

  dds_wave_gen #(.PHASE_W(32), .LUT_AW(6), .DAC_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fre_k     (fre_k),
    .en        (en),
    .wave_sel  (wave_sel),
    .phase_off (phase_off),
    .dac_data  (dac_data),
    .wrap_sync (wrap_sync)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Entry layout: {care, wrap, dac}
  logic [9:0] exp_q[$];
  int         due_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  logic [31:0] m_tw;
  logic [31:0] m_acc;
  logic        m_wrap;

  // Expected waveform sample for phase p; care=0 where no hand value is tabulated.
  // Sine values are listed at every 16th phase: 128 +/- round(127*sin(pi*i/128)).
  function automatic logic [8:0] exp_wave(input logic [1:0] sel, input logic [7:0] p);
    logic [7:0] t;
    case (sel)
      2'd1: begin
        t = {p[6:0], 1'b0};
        return {1'b1, p[7] ? ~t : t};
      end
      2'd2: return {1'b1, p};
      2'd3: return {1'b1, p[7] ? 8'h00 : 8'hFF};
      default: begin
        case (p)
          8'd0:   return {1'b1, 8'd128};
          8'd16:  return {1'b1, 8'd177};
          8'd32:  return {1'b1, 8'd218};
          8'd48:  return {1'b1, 8'd245};
          8'd64:  return {1'b1, 8'd255};
          8'd80:  return {1'b1, 8'd244};
          8'd96:  return {1'b1, 8'd216};
          8'd112: return {1'b1, 8'd174};
          8'd128: return {1'b1, 8'd128};
          8'd144: return {1'b1, 8'd79};
          8'd160: return {1'b1, 8'd38};
          8'd176: return {1'b1, 8'd11};
          8'd192: return {1'b1, 8'd1};
          8'd208: return {1'b1, 8'd12};
          8'd224: return {1'b1, 8'd40};
          8'd240: return {1'b1, 8'd82};
          default: return {1'b0, 8'd0};
        endcase
      end
    endcase
  endfunction

  task automatic push_exp(input int due, input logic care, input logic w, input logic [7:0] d);
    exp_q.push_back({care, w, d});
    due_q.push_back(due);
  endtask

  // Reference model: on each edge predict the sample due two edges later,
  // then advance the model accumulator with the previously registered tuning word.
  always @(posedge clk) begin
    logic [8:0]  ew;
    logic [7:0]  p;
    logic [32:0] s;
    cyc = cyc + 1;
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      push_exp(cyc,     1'b1, 1'b0, 8'h80);
      push_exp(cyc + 1, 1'b1, 1'b0, 8'h80);
      push_exp(cyc + 2, 1'b1, 1'b0, 8'd128);
      m_tw   = '0;
      m_acc  = '0;
      m_wrap = 1'b0;
    end else begin
      p  = m_acc[31:24] + phase_off;
      ew = exp_wave(wave_sel, p);
      push_exp(cyc + 2, ew[8], m_wrap, ew[7:0]);
      if (en) begin
        s      = {1'b0, m_acc} + {1'b0, m_tw};
        m_acc  = s[31:0];
        m_wrap = s[32];
      end else begin
        m_wrap = 1'b0;
      end
      m_tw = fre_k;
    end
  end

  // Monitor: compare each DUT sample against the entry due on this edge
  always @(negedge clk) begin
    logic [9:0] e;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      e = exp_q.pop_front();
      if (due_q[0] < cyc) begin
        n_checks++;
        $display("FAIL stale_entry cyc=%0d due=%0d never compared", cyc, due_q[0]);
      end else if (e[9]) begin
        n_checks++;
        if (dac_data === e[7:0] && wrap_sync === e[8]) begin
          n_pass++;
        end else begin
          $display("FAIL sample cyc=%0d sel=%0d got dac=%02h wrap=%0b expected dac=%02h wrap=%0b",
                   cyc, wave_sel, dac_data, wrap_sync, e[7:0], e[8]);
        end
      end
      void'(due_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] f, input logic e, input logic [1:0] s, input logic [7:0] o);
    fre_k     = f;
    en        = e;
    wave_sel  = s;
    phase_off = o;
  endtask

  initial begin
    rst_n = 1'b0;
    // Saw sweep, tuning word already present during reset
    set_in(32'h0100_0000, 1'b1, 2'd2, 8'h00);
    tick(3);
    rst_n = 1'b1;
    tick(300);

    // Enable hold mid-sweep
    en = 1'b0;
    tick(20);
    en = 1'b1;
    tick(30);

    // Frequency step to slope 2, then back
    fre_k = 32'h0200_0000;
    tick(40);
    fre_k = 32'h0100_0000;
    tick(10);

    // Square and triangle with half-cycle offset
    wave_sel  = 2'd3;
    phase_off = 8'h80;
    tick(270);
    wave_sel = 2'd1;
    tick(270);

    // Sine quadrants with a one-clock reset mid-run
    set_in(32'h4000_0000, 1'b1, 2'd0, 8'h00);
    tick(6);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(20);

    // Finer sine steps, offset, reverse rotation, zero tuning word, hold
    fre_k = 32'h1000_0000;
    tick(40);
    phase_off = 8'h10;
    tick(20);
    fre_k = 32'hF000_0000;
    tick(30);
    fre_k = 32'h0000_0000;
    tick(10);
    fre_k = 32'h3000_0000;
    en    = 1'b0;
    tick(6);
    en = 1'b1;
    tick(12);

    @(negedge clk);
    #1;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      n_checks++;
      $display("FAIL drain cyc=%0d due=%0d entry not compared", cyc, due_q[0]);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
